uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side handshake and status bundle for uart_rx.
// master = the receiver, slave = the byte consumer.
`timescale 1ns/1ps
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output rx_data, rx_valid, busy, frame_err, overrun, parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, busy, frame_err, overrun, parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority vote and valid/ready output.
// Optional even parity bit: define UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx #(
  parameter int clk_freq = 12000000,
  parameter int baud     = 115200
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     rx,
  uart_rx_if.master bus
);

  // Accumulator wide enough that the 16x tick period error stays well below 1%.
  localparam int     RATIO = (clk_freq + baud - 1) / baud;
  localparam int     W     = $clog2(RATIO) + 8;
  localparam longint INC_L = (longint'(baud) * 64'sd16 * (longint'(1) << W)
                              + longint'(clk_freq) / 2) / longint'(clk_freq);
  localparam logic [W-1:0] INC = INC_L[W-1:0];

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t       state_reg, state_next;
  logic         rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [W-1:0] acc_reg;
  logic [W:0]   acc_sum;
  logic         tick;
  logic [3:0]   cnt_reg, cnt_next;
  logic [1:0]   smp_reg, smp_next;
  logic [2:0]   bit_reg, bit_next;
  logic [7:0]   shift_reg, shift_next;
  logic         par_bad_reg, par_bad_next;
  logic [7:0]   rx_data_reg;
  logic         rx_valid_reg;
  logic         frame_err_reg, frame_err_next;
  logic         parity_err_reg, parity_err_next;
  logic         overrun_reg;
  logic         deliver;
  logic         maj, decide, wrap, fall;

  assign acc_sum = {1'b0, acc_reg} + {1'b0, INC};
  assign tick    = acc_sum[W];
  assign decide  = tick && (cnt_reg == 4'd9);
  assign wrap    = tick && (cnt_reg == 4'd15);
  assign fall    = rx_prev_reg && !rx_sync_reg;
  // Third vote is the live sample taken on the count-9 tick.
  assign maj     = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & rx_sync_reg)
                 | (smp_reg[1] & rx_sync_reg);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = tick ? cnt_reg + 4'd1 : cnt_reg;
    smp_next        = smp_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    par_bad_next    = par_bad_reg;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    deliver         = 1'b0;

    if (tick && cnt_reg == 4'd7) smp_next[0] = rx_sync_reg;
    if (tick && cnt_reg == 4'd8) smp_next[1] = rx_sync_reg;

    case (state_reg)
      IDLE: begin
        cnt_next     = 4'd0;
        bit_next     = 3'd0;
        par_bad_next = 1'b0;
        if (fall) state_next = START;
      end
      START: begin
        if (decide && maj) state_next = IDLE;
        else if (wrap)     state_next = DATA;
      end
      DATA: begin
        if (decide) shift_next = {maj, shift_reg[7:1]};
        if (wrap) begin
          if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide) begin
          par_bad_next    = ^{shift_reg, maj};
          parity_err_next = ^{shift_reg, maj};
        end
        if (wrap) state_next = STOP;
      end
`endif
      STOP: begin
        // Decide mid stop bit so back-to-back frames keep half a bit of margin.
        if (decide) begin
          if (maj) begin
            deliver    = !par_bad_reg;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_prev_reg    <= 1'b1;
      state_reg      <= IDLE;
      acc_reg        <= '0;
      cnt_reg        <= 4'd0;
      smp_reg        <= 2'd0;
      bit_reg        <= 3'd0;
      shift_reg      <= 8'd0;
      par_bad_reg    <= 1'b0;
      rx_data_reg    <= 8'd0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      rx_meta_reg    <= rx;
      rx_sync_reg    <= rx_meta_reg;
      rx_prev_reg    <= rx_sync_reg;
      state_reg      <= state_next;
      // Reloading in IDLE restarts the tick phase at every start edge.
      acc_reg        <= (state_reg == IDLE) ? INC : acc_sum[W-1:0];
      cnt_reg        <= cnt_next;
      smp_reg        <= smp_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      par_bad_reg    <= par_bad_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      overrun_reg    <= deliver && rx_valid_reg && !bus.rx_ready;
      if (deliver) rx_data_reg <= shift_reg;
      if (deliver)                rx_valid_reg <= 1'b1;
      else if (bus.rx_ready)      rx_valid_reg <= 1'b0;
    end
  end

  assign bus.rx_data    = rx_data_reg;
  assign bus.rx_valid   = rx_valid_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.frame_err  = frame_err_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.parity_err = parity_err_reg;

endmodule
